ultrasonic_ranger_ctrl: RTL and testbench

//   Sequences an HC-SR04-class ultrasonic sensor: fires a trigger pulse, times the echo,

---
 rtl/ultrasonic_ranger_ctrl_pkg.sv | 29 ++
 rtl/ultrasonic_ranger_ctrl_us_tick_gen.sv | 33 +++
 rtl/ultrasonic_ranger_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_ultrasonic_ranger_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/ultrasonic_ranger_ctrl_pkg.sv
// Shared definitions for the ultrasonic ranger controller:
// FSM state encoding, result codes and default timing constants.
package ultrasonic_ranger_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRIG      = 3'd1,
    ST_WAIT_RISE = 3'd2,
    ST_MEASURE   = 3'd3,
    ST_HOLDOFF   = 3'd4
  } state_t;

  // Distance code for "no target / timeout"
  localparam logic [15:0] TIMEOUT_DIST = 16'hFFFF;
  // Largest real distance; keeps a valid result from aliasing the timeout code
  localparam logic [15:0] CM_SAT       = 16'hFFFE;

  localparam int DEF_CLK_HZ     = 50_000_000;
  localparam int DEF_TRIG_US    = 10;
  localparam int DEF_TIMEOUT_US = 25_000;
  localparam int DEF_PERIOD_MS  = 60;
  localparam int DEF_US_PER_CM  = 58;

  // Increment that sticks at CM_SAT
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v >= CM_SAT) ? CM_SAT : v + 16'd1;
  endfunction

endpackage

// File: rtl/ultrasonic_ranger_ctrl_us_tick_gen.sv
// 1 us strobe generator: down-counter reloaded at terminal count.
// clr restarts the count so the first strobe lands a full microsecond later.
module us_tick_gen
  import ultrasonic_ranger_ctrl_pkg::*;
#(
  parameter int CLK_HZ = DEF_CLK_HZ
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int DIV = (CLK_HZ / 1_000_000 > 0) ? CLK_HZ / 1_000_000 : 1;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LOAD = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Down-count one microsecond worth of clocks, reload at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || cnt == '0) begin
      cnt <= LOAD;
    end else begin
      cnt <= cnt - CW'(1);
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/ultrasonic_ranger_ctrl.sv
// HC-SR04-class ranger sequencer: trigger pulse, echo timing, cm conversion,
// periodic re-triggering while enabled.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | stopped, waiting for en
// TRIG       | driving trigger pulse for TRIG_US
// WAIT_RISE  | waiting for echo rising edge, bounded by TIMEOUT_US
// MEASURE    | echo high, counting us and cm, bounded by TIMEOUT_US
// HOLDOFF    | waiting out PERIOD_MS from last trigger rise
module ultrasonic_ranger_ctrl
  import ultrasonic_ranger_ctrl_pkg::*;
#(
  parameter int CLK_HZ     = DEF_CLK_HZ,
  parameter int TRIG_US    = DEF_TRIG_US,
  parameter int TIMEOUT_US = DEF_TIMEOUT_US,
  parameter int PERIOD_MS  = DEF_PERIOD_MS,
  parameter int US_PER_CM  = DEF_US_PER_CM
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        echo,
  output logic        trig,
  output logic [15:0] distance,
  output logic        valid,
  output logic        timeout,
  output logic        busy
);

  localparam logic [31:0] TRIG_LOAD   = 32'(TRIG_US - 1);
  localparam logic [31:0] TO_LOAD     = 32'(TIMEOUT_US - 1);
  localparam logic [31:0] PERIOD_LOAD = 32'(PERIOD_MS * 1000 - 1);
  localparam logic [15:0] US_LAST     = 16'(US_PER_CM - 1);

  state_t      state;
  logic        echo_s1, echo_s2, echo_d;
  logic        echo_rise, echo_fall;
  logic        tick;
  logic        period_done;
  logic        start_trig;
  logic [31:0] tmr;
  logic [31:0] period_cnt;
  logic [15:0] us_cnt, cm_cnt;
  logic [15:0] us_next, cm_next;

  us_tick_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (start_trig),
    .tick(tick)
  );

  // Two-flop synchroniser on echo plus one delay stage for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      echo_s1 <= 1'b0;
      echo_s2 <= 1'b0;
      echo_d  <= 1'b0;
    end else begin
      echo_s1 <= echo;
      echo_s2 <= echo_s1;
      echo_d  <= echo_s2;
    end
  end

  assign echo_rise = echo_s2 & ~echo_d;
  assign echo_fall = ~echo_s2 & echo_d;

  // Period is qualified by tick so the next trigger lands exactly on the
  // PERIOD_MS boundary, whatever the clock divide ratio.
  assign period_done = tick && (period_cnt == '0);
  assign start_trig  = en && ((state == ST_IDLE) ||
                              (state == ST_HOLDOFF && period_done));

  // Trigger-to-trigger spacing counter, armed on every trigger rise
  always_ff @(posedge clk) begin
    if (rst) begin
      period_cnt <= '0;
    end else if (start_trig) begin
      period_cnt <= PERIOD_LOAD;
    end else if (tick && period_cnt != '0) begin
      period_cnt <= period_cnt - 32'd1;
    end
  end

  // Counter values after this cycle's tick; the falling-edge cycle's tick is
  // included so the result covers every microsecond the echo was high.
  always_comb begin
    us_next = us_cnt;
    cm_next = cm_cnt;
    if (tick) begin
      if (us_cnt >= US_LAST) begin
        us_next = '0;
        cm_next = sat_inc16(cm_cnt);
      end else begin
        us_next = us_cnt + 16'd1;
      end
    end
  end

  // Measurement sequencer with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      trig     <= 1'b0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      timeout  <= 1'b0;
      distance <= 16'h0000;
      tmr      <= '0;
      us_cnt   <= '0;
      cm_cnt   <= '0;
    end else begin
      valid   <= 1'b0;
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_trig) begin
            state <= ST_TRIG;
            trig  <= 1'b1;
            busy  <= 1'b1;
            tmr   <= TRIG_LOAD;
          end
        end

        ST_TRIG: begin
          if (tick) begin
            if (tmr == '0) begin
              trig  <= 1'b0;
              tmr   <= TO_LOAD;
              state <= ST_WAIT_RISE;
            end else begin
              tmr <= tmr - 32'd1;
            end
          end
        end

        ST_WAIT_RISE: begin
          if (echo_rise) begin
            state  <= ST_MEASURE;
            us_cnt <= '0;
            cm_cnt <= '0;
            tmr    <= TO_LOAD;
          end else if (tick) begin
            if (tmr == '0) begin
              distance <= TIMEOUT_DIST;
              valid    <= 1'b1;
              timeout  <= 1'b1;
              busy     <= 1'b0;
              state    <= ST_HOLDOFF;
            end else begin
              tmr <= tmr - 32'd1;
            end
          end
        end

        ST_MEASURE: begin
          if (echo_fall) begin
            distance <= cm_next;
            valid    <= 1'b1;
            busy     <= 1'b0;
            state    <= ST_HOLDOFF;
          end else begin
            us_cnt <= us_next;
            cm_cnt <= cm_next;
            if (tick) begin
              if (tmr == '0) begin
                distance <= TIMEOUT_DIST;
                valid    <= 1'b1;
                timeout  <= 1'b1;
                busy     <= 1'b0;
                state    <= ST_HOLDOFF;
              end else begin
                tmr <= tmr - 32'd1;
              end
            end
          end
        end

        ST_HOLDOFF: begin
          if (period_done) begin
            if (en) begin
              state <= ST_TRIG;
              trig  <= 1'b1;
              busy  <= 1'b1;
              tmr   <= TRIG_LOAD;
            end else begin
              state <= ST_IDLE;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ultrasonic_ranger_ctrl.sv
// Directed bench for ultrasonic_ranger_ctrl at 1 MHz (1 cycle = 1 us), 2 ms period.
module tb_ultrasonic_ranger_ctrl;
  import ultrasonic_ranger_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst, en, echo;
  logic        trig, valid, timeout, busy;
  logic [15:0] distance;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  ultrasonic_ranger_ctrl #(
    .CLK_HZ    (1_000_000),
    .TRIG_US   (10),
    .TIMEOUT_US(25_000),
    .PERIOD_MS (2),
    .US_PER_CM (58)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .echo    (echo),
    .trig    (trig),
    .distance(distance),
    .valid   (valid),
    .timeout (timeout),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_trig(input logic level, input int limit, input string tag, output int n);
    n = 0;
    while (trig !== level && n < limit) begin
      step();
      n++;
    end
    chk(tag, {31'b0, trig === level}, 32'd1);
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    while (valid !== 1'b1 && n < limit) begin
      step();
      n++;
    end
  endtask

  int widths [4] = '{1160, 57, 58, 1217};
  int exp_cm [4] = '{20, 0, 1, 20};

  initial begin
    int n, t_rise, t_prev, t0, hi;
    rst  = 1'b1;
    en   = 1'b0;
    echo = 1'b0;
    repeat (3) step();
    chk("rst_trig", trig, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_dist", distance, 0);
    rst = 1'b0;
    step();

    // periodic measurements with en held high
    en = 1'b1;
    t_prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_trig(1'b1, 2100, "trig_rise", n);
      t_rise = cyc;
      if (i > 0) chk("period", t_rise - t_prev, 2000);
      t_prev = t_rise;
      if (i == 0) begin
        chk("busy_trig", busy, 1);
        chk("valid_trig", valid, 0);
        chk("dist_trig", distance, 0);
      end
      wait_trig(1'b0, 20, "trig_fall", n);
      if (i == 0) chk("trig_width", n, 10);
      echo = 1'b1;
      repeat (widths[i]) step();
      echo = 1'b0;
      repeat (3) step();
      chk("meas_valid", valid, 1);
      chk("meas_dist", distance, exp_cm[i]);
      chk("meas_timeout", timeout, 0);
      chk("meas_busy", busy, 0);
      step();
      chk("meas_valid_1cyc", valid, 0);
      chk("meas_dist_hold", distance, exp_cm[i]);
    end

    // en dropped during MEASURE: result still published, then no retrigger
    wait_trig(1'b1, 2100, "trig_rise_5b", n);
    chk("period_5b", cyc - t_prev, 2000);
    wait_trig(1'b0, 20, "trig_fall_5b", n);
    echo = 1'b1;
    repeat (100) step();
    en = 1'b0;
    repeat (200) step();
    echo = 1'b0;
    repeat (3) step();
    chk("en_off_valid", valid, 1);
    chk("en_off_dist", distance, 5);
    hi = 0;
    repeat (3000) begin
      step();
      if (trig) hi++;
    end
    chk("no_retrig", hi, 0);
    chk("idle_state", dut.state, ST_IDLE);
    chk("idle_busy", busy, 0);

    // echo never rises
    en = 1'b1;
    wait_trig(1'b1, 5, "trig_rise_3", n);
    wait_trig(1'b0, 20, "trig_fall_3", n);
    wait_valid(26000, n);
    chk("norise_latency", n, 25000);
    chk("norise_dist", distance, 16'hFFFF);
    chk("norise_timeout", timeout, 1);
    en = 1'b0;
    step();
    chk("norise_valid_1cyc", valid, 0);
    chk("norise_timeout_1cyc", timeout, 0);
    chk("norise_dist_hold", distance, 16'hFFFF);

    // echo stuck high
    en = 1'b1;
    wait_trig(1'b1, 5, "trig_rise_4", n);
    t0 = cyc;
    wait_trig(1'b0, 20, "trig_fall_4", n);
    echo = 1'b1;
    wait_valid(26000, n);
    chk("stuck_latency", n, 25003);
    chk("stuck_dist", distance, 16'hFFFF);
    chk("stuck_timeout", timeout, 1);
    echo = 1'b0;
    wait_trig(1'b1, 10, "trig_rise_4b", n);
    chk("rearm_gap", cyc - t0, 25014);

    // reset during MEASURE
    wait_trig(1'b0, 20, "trig_fall_6", n);
    echo = 1'b1;
    repeat (50) step();
    chk("pre_rst_state", dut.state, ST_MEASURE);
    rst = 1'b1;
    en  = 1'b0;
    step();
    chk("mid_rst_trig", trig, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_dist", distance, 0);
    chk("mid_rst_state", dut.state, ST_IDLE);
    rst  = 1'b0;
    echo = 1'b0;
    hi = 0;
    repeat (20) begin
      step();
      if (trig || valid) hi++;
    end
    chk("post_rst_quiet", hi, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
